output4to1_arbiter: RTL
=======================

Name: output4to1_arbiter

Overview:
- Clocked 4-to-1 merge stage downstream of the router input demux.
- One instance per router output port. Its four input channels come from outs[] of four different input-port demuxes, and its single output channel drives the link or local port.
- Receives 2-phase bundled-data (req/ack transition) channels, synchronises them into the clk domain, grants one requester at a time in round-robin order, and forwards the flit on a 2-phase output channel.

Parameters:
n, 32, flit width in bits, matching the demux data width.
SYNC_STAGES, 2, flip-flop depth of every req/ack synchroniser; minimum 2.

Ports:
clk  input  1  block clock.
rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state.
in_req  input  4  2-phase request per input channel; index 0..3 matches demux outD, outC, outB, outE.
in_ack  output  4  2-phase acknowledge per input channel.
in_data  input  4 x n  bundled data per input channel; stable while in_req != in_ack.
out_req  output  1  2-phase output request.
out_ack  input  1  2-phase output acknowledge.
out_data  output  n  registered output flit.
busy  output  1  high from grant until the input ack is toggled.

Behaviour:
- Reset (rst=0) forces the following, with no clock needed:
  - state=IDLE, in_ack=4'b0, out_req=0, out_data=0, busy=0.
  - Round-robin pointer ptr=0; all synchroniser flops=0.
- Synchronisers:
  - in_req[i] passes through SYNC_STAGES flops to give rq_s[i].
  - out_ack passes through SYNC_STAGES flops to give ak_s.
- Pending: pend[i] = rq_s[i] XOR in_ack[i].
- FSM:
  - IDLE: if any pend, grant g = first pending index scanning ptr, ptr+1, ... modulo 4. Set out_data <= in_data[g], busy <= 1, and go to LAUNCH. With no pending request, hold.
  - LAUNCH: out_req <= ~out_req, then go to WAIT. The data register is written one cycle before the req toggle, which keeps the bundled-data ordering.
  - WAIT: stay until ak_s == out_req, then go to RELEASE.
  - RELEASE: in_ack[g] <= ~in_ack[g], ptr <= (g+1) mod 4, busy <= 0, then go to IDLE.
- Latency:
  - in_req toggle to out_req toggle: SYNC_STAGES+2 cycles, counting from the first clk edge that samples the toggle. With the default this is 4.
  - out_ack toggle to in_ack toggle: SYNC_STAGES+1 cycles, which is 3 with the default.
  - Minimum throughput: one flit per 2*SYNC_STAGES+3 cycles plus upstream and downstream response time.
- Simultaneous requests: exactly one grant per IDLE visit, chosen by ptr. A continuously requesting input waits at most 3 other grants.
- New toggle on a granted input while not in IDLE: ignored until the next IDLE, because pend only becomes visible after in_ack flips.
- out_ack toggling while not in WAIT is a protocol error. It is not tracked; the sync value is simply compared at WAIT.
- out_data holds its value between transfers and is never cleared except by reset.
- Reset mid-transfer aborts the transfer. Neighbouring channels must be reset together so that all phases return to 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: OUT_ARB_GRANT_CNT_EN.
- With the macro defined:
  - The block adds output port grant_cnt (4 x 16), one counter per input.
  - Each counter increments on RELEASE for that input and saturates at 16'hFFFF.
  - Counters reset to 0 on rst=0.
- Without the macro: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 and toggle clk and inputs. Required: in_ack=0, out_req=0, out_data=0, busy=0. After release with no in_req toggles, nothing changes for 20 cycles.
- Single flit: toggle in_req[2] with in_data[2]=32'hA5A5_0001. Required: out_data=32'hA5A5_0001 one cycle before out_req goes 0->1, which is 4 cycles after sampling. Toggle out_ack, and in_ack[2] must go 0->1 3 cycles later.
- Round-robin: after reset, toggle all four in_req at once with data 0x10..0x13 and the bench acks each out_req. Required: output order 0x10, 0x11, 0x12, 0x13; ptr ends at 0.
- Fairness: inputs 0 and 3 request continuously, re-toggling immediately after each ack, for 8 flits. Required: grants alternate 0, 3, 0, 3, ... with 4 each.
- Backpressure: hold out_ack for 50 cycles after an out_req toggle. Required: state stays WAIT, busy=1, out_data stable, no in_ack change, and further in_req toggles do not corrupt out_data.
- Reset mid-WAIT: assert rst=0 while waiting. Required: all outputs return to 0 immediately. With the macro defined, grant_cnt also reads 0 and increments to 1 per input after one flit each.

Source files
------------

// File: rtl/output4to1_arbiter.sv
// rtl/output4to1_arbiter.sv - 4-to-1 round-robin merge of 2-phase bundled-data channels
//
// Optional feature macro: OUT_ARB_GRANT_CNT_EN (adds per-input grant counters).
//
// Ports:
//   clk        block clock
//   rst        asynchronous active-low reset; clears every flop
//   in_req     [3:0] 2-phase request per input (index 0..3 = demux outD, outC, outB, outE)
//   in_ack     [3:0] 2-phase acknowledge per input
//   in_data    [3:0][n-1:0] bundled flit per input, stable while in_req != in_ack
//   out_req    2-phase output request
//   out_ack    2-phase output acknowledge
//   out_data   [n-1:0] registered output flit, held between transfers
//   busy       high from grant until the granted input is acknowledged
//   grant_cnt  [3:0][15:0] saturating grant count per input (macro only)

module output4to1_arbiter #(
  parameter int n           = 32,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_req,
  output logic [3:0]          in_ack,
  input  logic [3:0][n-1:0]   in_data,
  output logic                out_req,
  input  logic                out_ack,
  output logic [n-1:0]        out_data,
  output logic                busy
`ifdef OUT_ARB_GRANT_CNT_EN
  ,
  output logic [3:0][15:0]    grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]    rq_sync_q, rq_sync_d;
  logic [SYNC_STAGES-1:0]         ak_sync_q, ak_sync_d;
  logic [1:0]                     ptr_q, ptr_d;
  logic [1:0]                     grant_q, grant_d;
  logic [3:0]                     in_ack_q, in_ack_d;
  logic                           out_req_q, out_req_d;
  logic [n-1:0]                   out_data_q, out_data_d;
  logic                           busy_q, busy_d;
`ifdef OUT_ARB_GRANT_CNT_EN
  logic [3:0][15:0]               grant_cnt_q, grant_cnt_d;
`endif

  logic [3:0] rq_s;
  logic       ak_s;
  logic [3:0] pend;
  logic       any_pend;
  logic [1:0] grant_sel;
  logic [1:0] scan_idx;

  // Synchroniser chains: stage 0 samples the raw input, the last stage is the
  // clk-domain view.
  always_comb begin
    rq_sync_d = {rq_sync_q[SYNC_STAGES-2:0], in_req};
    ak_sync_d = {ak_sync_q[SYNC_STAGES-2:0], out_ack};
  end

  assign rq_s     = rq_sync_q[SYNC_STAGES-1];
  assign ak_s     = ak_sync_q[SYNC_STAGES-1];
  assign pend     = rq_s ^ in_ack_q;
  assign any_pend = |pend;

  // Round-robin pick: scan offsets 3..0 from ptr so the smallest offset that
  // is pending is the one left in grant_sel.
  always_comb begin
    grant_sel = ptr_q;
    scan_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (pend[scan_idx]) begin
        grant_sel = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    in_ack_d   = in_ack_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    busy_d     = busy_q;
`ifdef OUT_ARB_GRANT_CNT_EN
    grant_cnt_d = grant_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_pend) begin
          grant_d    = grant_sel;
          out_data_d = in_data[grant_sel];
          busy_d     = 1'b1;
          state_d    = LAUNCH;
        end
      end

      // Data was registered on the previous edge, so it is already stable
      // when the request toggles.
      LAUNCH: begin
        out_req_d = ~out_req_q;
        state_d   = WAIT;
      end

      // Release bookkeeping is committed on the edge that leaves WAIT so the
      // input ack follows the synchronised output ack by one clock.
      WAIT: begin
        if (ak_s == out_req_q) begin
          in_ack_d[grant_q] = ~in_ack_q[grant_q];
          ptr_d             = grant_q + 2'd1;
          busy_d            = 1'b0;
`ifdef OUT_ARB_GRANT_CNT_EN
          if (grant_cnt_q[grant_q] != 16'hFFFF) begin
            grant_cnt_d[grant_q] = grant_cnt_q[grant_q] + 16'd1;
          end
`endif
          state_d = RELEASE;
        end
      end

      // One settle cycle: pend of the released input is recomputed from the
      // new in_ack before the next IDLE scan.
      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rq_sync_q  <= '0;
      ak_sync_q  <= '0;
      ptr_q      <= 2'd0;
      grant_q    <= 2'd0;
      in_ack_q   <= 4'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
`ifdef OUT_ARB_GRANT_CNT_EN
      grant_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rq_sync_q  <= rq_sync_d;
      ak_sync_q  <= ak_sync_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
`ifdef OUT_ARB_GRANT_CNT_EN
      grant_cnt_q <= grant_cnt_d;
`endif
    end
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;
`ifdef OUT_ARB_GRANT_CNT_EN
  assign grant_cnt = grant_cnt_q;
`endif

endmodule
